// File: rtl/pigasus_to_axis.sv
// pigasus_to_axis
//   Return-path adapter from the Pigasus Avalon-ST user stream to AXI Stream.
//   The input carries sop/eop/empty framing with the first wire byte in the MSB
//   lane. The output is AXIS with tkeep/tlast and the first wire byte in lane 0.
//   Framing is policed: beats outside a packet are dropped and counted, and a
//   repeated sop inside a packet is flagged but forwarded as a continuation.
//   An output register plus one skid entry give full-rate throughput with a
//   registered in_usr_ready.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_usr_*             Avalon-ST user stream in (data, empty, valid, sop, eop, ready)
//   m_axis_*             AXI Stream out (tdata, tkeep, tvalid, tlast, tready)
//   err_no_sop           1-cycle pulse: beat outside a packet was dropped
//   err_dup_sop          1-cycle pulse: sop seen inside a packet
//   drop_cnt             saturating count of dropped beats
//   m_axis_tuser_len     (PIGASUS_TO_AXIS_LEN_EN only) packet byte count on tlast beats
//
// Configuration macro: PIGASUS_TO_AXIS_LEN_EN
module pigasus_to_axis #(
   parameter int BYTE_COUNT = 16,
   parameter int EMPTY_W    = $clog2(BYTE_COUNT),
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [BYTE_COUNT*8-1:0] in_usr_data,
   input  logic [EMPTY_W-1:0]      in_usr_empty,
   input  logic                    in_usr_valid,
   input  logic                    in_usr_sop,
   input  logic                    in_usr_eop,
   output logic                    in_usr_ready,
   output logic [BYTE_COUNT*8-1:0] m_axis_tdata,
   output logic [BYTE_COUNT-1:0]   m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    err_no_sop,
   output logic                    err_dup_sop,
   output logic [CNT_W-1:0]        drop_cnt
`ifdef PIGASUS_TO_AXIS_LEN_EN
   ,output logic [15:0]            m_axis_tuser_len
`endif
);

   localparam int DATA_W = BYTE_COUNT * 8;

   typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

   state_t state_q, state_d;

   logic                  ready_q, ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_W-1:0]     out_data_q, out_data_d;
   logic [BYTE_COUNT-1:0] out_keep_q, out_keep_d;
   logic                  out_last_q, out_last_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0]     skid_data_q, skid_data_d;
   logic [BYTE_COUNT-1:0] skid_keep_q, skid_keep_d;
   logic                  skid_last_q, skid_last_d;
   logic                  err_no_sop_q, err_no_sop_d;
   logic                  err_dup_sop_q, err_dup_sop_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

   logic [DATA_W-1:0]     beat_data;
   logic [BYTE_COUNT-1:0] beat_keep;
   logic                  accept;
   logic                  fwd;

`ifdef PIGASUS_TO_AXIS_LEN_EN
   logic [15:0] out_len_q, out_len_d;
   logic [15:0] skid_len_q, skid_len_d;
   logic [15:0] len_cnt_q, len_cnt_d;
   logic [16:0] beat_bytes;
   logic [16:0] len_sum;
   logic [15:0] len_total;
   logic [15:0] beat_len;
`endif

   // Byte-lane reversal and keep generation for the incoming beat. A lane is
   // kept on an eop beat when its index is below BYTE_COUNT - empty.
   genvar gi;
   generate
      for (gi = 0; gi < BYTE_COUNT; gi++) begin : g_lane
         assign beat_data[gi*8 +: 8] = in_usr_data[(BYTE_COUNT-1-gi)*8 +: 8];
         assign beat_keep[gi] = !in_usr_eop ||
                                ({1'b0, in_usr_empty} < (EMPTY_W+1)'(BYTE_COUNT - gi));
      end
   endgenerate

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_keep_d    = out_keep_q;
      out_last_d    = out_last_q;
      skid_valid_d  = skid_valid_q;
      skid_data_d   = skid_data_q;
      skid_keep_d   = skid_keep_q;
      skid_last_d   = skid_last_q;
      drop_cnt_d    = drop_cnt_q;

      accept        = in_usr_valid && ready_q;
      fwd           = accept && ((state_q == IN_PKT) || in_usr_sop);
      err_no_sop_d  = accept && (state_q == IDLE) && !in_usr_sop;
      err_dup_sop_d = accept && (state_q == IN_PKT) && in_usr_sop;

`ifdef PIGASUS_TO_AXIS_LEN_EN
      out_len_d  = out_len_q;
      skid_len_d = skid_len_q;
      len_cnt_d  = len_cnt_q;
      beat_bytes = in_usr_eop ? (17'(BYTE_COUNT) - 17'(in_usr_empty)) : 17'(BYTE_COUNT);
      // A forwarded beat in IDLE always carries sop, so the count restarts there.
      len_sum    = {1'b0, (state_q == IDLE) ? 16'd0 : len_cnt_q} + beat_bytes;
      len_total  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
      beat_len   = in_usr_eop ? len_total : 16'd0;
      if (fwd) begin
         len_cnt_d = len_total;
      end
`endif

      if (err_no_sop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end

      if (fwd) begin
         state_d = in_usr_eop ? IDLE : IN_PKT;
      end

      if (!out_valid_q || m_axis_tready) begin
         // Output register is free this cycle. A full skid means ready was low,
         // so no new beat can arrive at the same time.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_keep_d   = skid_keep_q;
            out_last_d   = skid_last_q;
            skid_valid_d = 1'b0;
`ifdef PIGASUS_TO_AXIS_LEN_EN
            out_len_d    = skid_len_q;
`endif
         end else begin
            out_valid_d = fwd;
            if (fwd) begin
               out_data_d = beat_data;
               out_keep_d = beat_keep;
               out_last_d = in_usr_eop;
`ifdef PIGASUS_TO_AXIS_LEN_EN
               out_len_d  = beat_len;
`endif
            end
         end
      end else if (fwd) begin
         // Output stalled and holding: park the new beat in the skid entry.
         skid_valid_d = 1'b1;
         skid_data_d  = beat_data;
         skid_keep_d  = beat_keep;
         skid_last_d  = in_usr_eop;
`ifdef PIGASUS_TO_AXIS_LEN_EN
         skid_len_d   = beat_len;
`endif
      end

      ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ready_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_keep_q    <= '0;
         out_last_q    <= 1'b0;
         skid_valid_q  <= 1'b0;
         skid_data_q   <= '0;
         skid_keep_q   <= '0;
         skid_last_q   <= 1'b0;
         err_no_sop_q  <= 1'b0;
         err_dup_sop_q <= 1'b0;
         drop_cnt_q    <= '0;
`ifdef PIGASUS_TO_AXIS_LEN_EN
         out_len_q     <= '0;
         skid_len_q    <= '0;
         len_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_keep_q    <= out_keep_d;
         out_last_q    <= out_last_d;
         skid_valid_q  <= skid_valid_d;
         skid_data_q   <= skid_data_d;
         skid_keep_q   <= skid_keep_d;
         skid_last_q   <= skid_last_d;
         err_no_sop_q  <= err_no_sop_d;
         err_dup_sop_q <= err_dup_sop_d;
         drop_cnt_q    <= drop_cnt_d;
`ifdef PIGASUS_TO_AXIS_LEN_EN
         out_len_q     <= out_len_d;
         skid_len_q    <= skid_len_d;
         len_cnt_q     <= len_cnt_d;
`endif
      end
   end

   assign in_usr_ready  = ready_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tlast  = out_last_q;
   assign err_no_sop    = err_no_sop_q;
   assign err_dup_sop   = err_dup_sop_q;
   assign drop_cnt      = drop_cnt_q;
`ifdef PIGASUS_TO_AXIS_LEN_EN
   assign m_axis_tuser_len = out_len_q;
`endif

endmodule

// File: tb/tb_pigasus_to_axis.sv
// tb_pigasus_to_axis
//   Directed stimulus for pigasus_to_axis. Each issued beat that should be
//   forwarded pushes its expected AXIS beat into a scoreboard queue; a monitor
//   pops and compares on every AXIS handshake. Error pulses and drop_cnt are
//   checked by the driver on the cycle after each accepted beat.
module tb_pigasus_to_axis;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_usr_data;
   logic [3:0]   in_usr_empty;
   logic         in_usr_valid;
   logic         in_usr_sop;
   logic         in_usr_eop;
   logic         in_usr_ready;
   logic [127:0] m_axis_tdata;
   logic [15:0]  m_axis_tkeep;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic         m_axis_tready;
   logic         err_no_sop;
   logic         err_dup_sop;
   logic [15:0]  drop_cnt;
`ifdef PIGASUS_TO_AXIS_LEN_EN
   logic [15:0]  m_axis_tuser_len;
`endif

   pigasus_to_axis #(.BYTE_COUNT(16), .EMPTY_W(4), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_usr_data   (in_usr_data),
      .in_usr_empty  (in_usr_empty),
      .in_usr_valid  (in_usr_valid),
      .in_usr_sop    (in_usr_sop),
      .in_usr_eop    (in_usr_eop),
      .in_usr_ready  (in_usr_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .err_no_sop    (err_no_sop),
      .err_dup_sop   (err_dup_sop),
      .drop_cnt      (drop_cnt)
`ifdef PIGASUS_TO_AXIS_LEN_EN
      ,.m_axis_tuser_len (m_axis_tuser_len)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
      logic [15:0]  len;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_drop = 0;
   int   tready_mode = 0;
   int   tr_phase = 0;
   int   beat_no = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // tready: held high, or the repeating pattern 1,0,0.
   always @(posedge clk) begin
      #1;
      if (tready_mode == 0) begin
         m_axis_tready = 1'b1;
      end else begin
         m_axis_tready = (tr_phase == 0);
         tr_phase = (tr_phase + 1) % 3;
      end
   end

   // Monitor: compare every AXIS handshake against the scoreboard and make sure
   // a stalled beat holds steady.
   logic         hold_prev = 1'b0;
   logic [127:0] prev_d;
   logic [15:0]  prev_k;
   logic         prev_l;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("stall_tvalid", 128'(m_axis_tvalid), 128'(1'b1));
            check("stall_tdata", m_axis_tdata, prev_d);
            check("stall_tkeep", 128'(m_axis_tkeep), 128'(prev_k));
            check("stall_tlast", 128'(m_axis_tlast), 128'(prev_l));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            exp_t e;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: actual tdata=%0h required no beat", m_axis_tdata);
            end else begin
               e = sb.pop_front();
               check("tdata", m_axis_tdata, e.d);
               check("tkeep", 128'(m_axis_tkeep), 128'(e.k));
               check("tlast", 128'(m_axis_tlast), 128'(e.l));
`ifdef PIGASUS_TO_AXIS_LEN_EN
               check("tuser_len", 128'(m_axis_tuser_len), 128'(e.len));
`endif
               $display("out beat %0d: tdata=%0h tkeep=%0h tlast=%0b", beat_no, m_axis_tdata,
                        m_axis_tkeep, m_axis_tlast);
               beat_no++;
            end
         end
         hold_prev = m_axis_tvalid && !m_axis_tready;
         prev_d = m_axis_tdata;
         prev_k = m_axis_tkeep;
         prev_l = m_axis_tlast;
      end
   end

   // Issue one beat whose wire bytes are base, base+1, ... Called at a negedge.
   task automatic send(input logic [7:0] base, input logic sop, input logic eop,
                       input logic [3:0] emp, input logic exp_fwd, input logic exp_nosop,
                       input logic exp_dup, input logic [15:0] exp_len,
                       input logic [15:0] exp_keep, input logic must_ready,
                       input string name);
      int   waits = 0;
      exp_t e;
      logic [7:0] b;
      for (int i = 0; i < 16; i++) begin
         b = base + 8'(i);
         in_usr_data[(15-i)*8 +: 8] = b;
         e.d[i*8 +: 8] = b;
      end
      e.k = exp_keep;
      e.l = eop;
      e.len = exp_len;
      in_usr_sop = sop;
      in_usr_eop = eop;
      in_usr_empty = emp;
      in_usr_valid = 1'b1;
      while (!in_usr_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_ready_timeout: actual ready=0 required ready=1", name);
         in_usr_valid = 1'b0;
         return;
      end
      if (must_ready) check({name, "_ready_wait"}, 128'(waits), 128'(0));
      if (exp_fwd) sb.push_back(e);
      if (exp_nosop) exp_drop++;
      @(posedge clk);
      @(negedge clk);
      in_usr_valid = 1'b0;
      check({name, "_err_no_sop"}, 128'(err_no_sop), 128'(exp_nosop));
      check({name, "_err_dup_sop"}, 128'(err_dup_sop), 128'(exp_dup));
      check({name, "_drop_cnt"}, 128'(drop_cnt), 128'(exp_drop));
      $display("in  %s: base=%0h sop=%0b eop=%0b empty=%0d waits=%0d", name, base, sop, eop,
               emp, waits);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, 128'(sb.size()), 128'(0));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ready"}, 128'(in_usr_ready), 128'(0));
      check({name, "_tvalid"}, 128'(m_axis_tvalid), 128'(0));
      check({name, "_tlast"}, 128'(m_axis_tlast), 128'(0));
      check({name, "_tkeep"}, 128'(m_axis_tkeep), 128'(0));
      check({name, "_tdata"}, m_axis_tdata, 128'(0));
      check({name, "_errs"}, 128'({err_no_sop, err_dup_sop}), 128'(0));
      check({name, "_drop_cnt"}, 128'(drop_cnt), 128'(0));
   endtask

   initial begin
      rst_n = 1'b0;
      in_usr_data = '0;
      in_usr_empty = '0;
      in_usr_valid = 1'b0;
      in_usr_sop = 1'b0;
      in_usr_eop = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 128'(in_usr_ready), 128'(0));
      @(negedge clk);
      check("ready_after_edge", 128'(in_usr_ready), 128'(1));

      // 1: 3-beat packet, 43 bytes, empty=5 on eop.
      send(8'h00, 1, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t1_b0");
      send(8'h10, 0, 0, 7, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t1_b1");
      send(8'h20, 0, 1, 5, 1, 0, 0, 16'd43, 16'h07FF, 0, "t1_b2");
      drain("t1");

      // 2: back-to-back single-beat packets; ready must never drop.
      for (int i = 0; i < 4; i++) begin
         send(8'(8'h40 + 8'(i*16)), 1, 1, 0, 1, 0, 0, 16'd16, 16'hFFFF, 1, "t2");
      end
      drain("t2");

      // 3: 8-beat packet with tready pattern 1,0,0.
      tready_mode = 1;
      for (int i = 0; i < 8; i++) begin
         send(8'(8'h80 + 8'(i*16)), (i == 0), (i == 7), 0, 1, 0, 0,
              (i == 7) ? 16'd128 : 16'd0, 16'hFFFF, 0, "t3");
      end
      drain("t3");
      tready_mode = 0;
      repeat (2) @(negedge clk);

      // 4: stray beat in IDLE is dropped, then a 2-beat packet (29 bytes).
      send(8'hD0, 0, 0, 0, 0, 1, 0, 16'd0, 16'hFFFF, 0, "t4_drop");
      send(8'h60, 1, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t4_b0");
      send(8'h70, 0, 1, 3, 1, 0, 0, 16'd29, 16'h1FFF, 0, "t4_b1");
      drain("t4");

      // 5: sop repeated on beat 2 of a 4-beat packet.
      send(8'h01, 1, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t5_b0");
      send(8'h11, 1, 0, 0, 1, 0, 1, 16'd0, 16'hFFFF, 0, "t5_b1");
      send(8'h21, 0, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t5_b2");
      send(8'h31, 0, 1, 0, 1, 0, 0, 16'd64, 16'hFFFF, 0, "t5_b3");
      drain("t5");

      // 6: reset after beat 2 of a 5-beat packet, then a fresh packet.
      send(8'hA0, 1, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t6_b0");
      send(8'hB0, 0, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t6_b1");
      drain("t6_pre");
      @(negedge clk);
      rst_n = 1'b0;
      exp_drop = 0;
      #1;
      check_reset_outputs("t6_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(8'hC0, 1, 0, 0, 1, 0, 0, 16'd0, 16'hFFFF, 0, "t6_n0");
      send(8'hE0, 0, 1, 15, 1, 0, 0, 16'd17, 16'h0001, 0, "t6_n1");
      drain("t6");
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
